qb_tone_sequencer: RTL

//   Parametrised successor to the single-voice music processor: an N-channel square-wave

---
 rtl/qb_tone_pkg.sv | 52 +++++
 rtl/qb_tone_gen.sv | 47 ++++
 rtl/qb_tone_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/qb_tone_pkg.sv
// Shared types and the note table for the multi-voice tone sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package qb_tone_pkg;

    localparam logic [5:0] CODE_REST = 6'd0;
    localparam logic [5:0] CODE_END  = 6'd63;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    // Half-period in 10 us units for codes 1..62 (code 1 = C3, semitone steps,
    // code 22 = A4 = 114). Octave-3 base values are held at 32x resolution and
    // divided down per octave with rounding. Rest/END/unused codes give 0.
    function automatic logic [11:0] note_hp(input logic [5:0] code);
        logic [13:0] base;
        logic [5:0]  idx;
        logic [2:0]  oct;
        logic [3:0]  semi;
        logic [19:0] scaled;
        base    = 14'd0;
        idx     = 6'd0;
        oct     = 3'd0;
        semi    = 4'd0;
        scaled  = 20'd0;
        note_hp = 12'd0;
        if (code != CODE_REST && code != CODE_END) begin
            idx  = code - 6'd1;
            oct  = (idx >= 6'd60) ? 3'd5 : (idx >= 6'd48) ? 3'd4 :
                   (idx >= 6'd36) ? 3'd3 : (idx >= 6'd24) ? 3'd2 :
                   (idx >= 6'd12) ? 3'd1 : 3'd0;
            semi = 4'(idx - 6'(oct) * 6'd12);
            case (semi)
                4'd0:    base = 14'd12231;  // C
                4'd1:    base = 14'd11545;  // C#
                4'd2:    base = 14'd10897;  // D
                4'd3:    base = 14'd10285;  // D#
                4'd4:    base = 14'd9708;   // E
                4'd5:    base = 14'd9163;   // F
                4'd6:    base = 14'd8649;   // F#
                4'd7:    base = 14'd8163;   // G
                4'd8:    base = 14'd7705;   // G#
                4'd9:    base = 14'd7273;   // A
                4'd10:   base = 14'd6865;   // A#
                4'd11:   base = 14'd6479;   // B
                default: base = 14'd0;
            endcase
            scaled  = {6'd0, base} + (20'd16 << oct);
            note_hp = 12'(scaled >> (4'd5 + 4'(oct)));
        end
    endfunction

endpackage

// File: rtl/qb_tone_gen.sv
// One square-wave voice: half-period counter toggling sq on 10 us ticks.
// Latency: note latched on the edge leaving LOAD; first rising edge HP ticks later.
// Backpressure: none; load/tick/silence are acted on every cycle.
module qb_tone_gen
    import qb_tone_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [5:0] code,
    input  logic       tick,
    input  logic       silence,
    output logic       sq
);

    logic [11:0] hp_q;
    logic [11:0] cnt_q;
    logic [11:0] hp_new;

    assign hp_new = note_hp(code);

    // Silence dominates; a load restarts the phase low; otherwise count down
    // and toggle on underflow. A zero half-period (rest/END) holds everything at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q  <= '0;
            cnt_q <= '0;
            sq    <= 1'b0;
        end else if (silence) begin
            hp_q  <= '0;
            cnt_q <= '0;
            sq    <= 1'b0;
        end else if (load) begin
            hp_q  <= hp_new;
            cnt_q <= (hp_new == 12'd0) ? 12'd0 : hp_new - 12'd1;
            sq    <= 1'b0;
        end else if (tick && hp_q != 12'd0) begin
            if (cnt_q == 12'd0) begin
                cnt_q <= hp_q - 12'd1;
                sq    <= ~sq;
            end else begin
                cnt_q <= cnt_q - 12'd1;
            end
        end
    end

endmodule

// File: rtl/qb_tone_sequencer.sv
// N-channel pattern tone sequencer with delta-sigma mix to a 1-bit speaker pair.
// Latency: start -> LOAD next cycle, PLAY the one after; led/playing lag state by 1 cycle.
// Backpressure: none; control pulses and RAM writes are accepted every cycle.
module qb_tone_sequencer
    import qb_tone_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int DEPTH           = 16,
    parameter int TICKS_PER_MILLI = 100,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [7:0]    tempo_ms,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_data,
    output logic          sound,
    output logic          sound_n,
    output logic [7:0]    led,
    output logic          playing
);

    localparam int DIV   = TICKS_PER_MILLI / 100;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ACC_W = $clog2(2 * N_CH) + 1;

    state_t            state_q, state_d;
    logic [AW-1:0]     step_q, step_d;
    logic [PW-1:0]     pre_q;
    logic [6:0]        ms_pre_q;
    logic              tone_tick, ms_tick;
    logic [7:0]        tempo_q, ms_cnt_q;
    logic              end_q, any_end, expire, silence;
    logic [5:0]        ram_q [N_CH][DEPTH];
    logic [5:0]        rd_code [N_CH];
    logic [N_CH-1:0]   sq;
    logic [ACC_W-1:0]  acc_q, k, acc_sum;

    // Free-running 10 us and 1 ms tick generators; never paused by start/stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            ms_pre_q <= '0;
        end else begin
            pre_q <= tone_tick ? '0 : pre_q + 1'b1;
            if (tone_tick) ms_pre_q <= (ms_pre_q == 7'd99) ? 7'd0 : ms_pre_q + 7'd1;
        end
    end

    assign tone_tick = (pre_q == PW'(DIV - 1));
    assign ms_tick   = tone_tick && (ms_pre_q == 7'd99);

    // Pattern RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && 32'(wr_ch) < N_CH) ram_q[wr_ch][wr_addr] <= wr_data;
    end

    // Asynchronous read of the current step; a same-edge write is seen only afterwards.
    always_comb begin
        any_end = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            rd_code[c] = ram_q[c][step_q];
            if (rd_code[c] == CODE_END) any_end = 1'b1;
        end
    end

    assign expire  = ms_tick && (ms_cnt_q == tempo_q - 8'd1);
    assign silence = (state_d == IDLE);

    // FSM state and step registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next state: stop beats start, start restarts from step 0 in any state.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (stop) begin
            state_d = IDLE;
            step_d  = '0;
        end else if (start) begin
            state_d = LOAD;
            step_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: state_d = PLAY;
                PLAY: begin
                    if (expire) begin
                        if (step_q == AW'(DEPTH - 1) || end_q) begin
                            step_d  = '0;
                            state_d = loop_en ? LOAD : IDLE;
                        end else begin
                            step_d  = step_q + 1'b1;
                            state_d = LOAD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Step timing: tempo and END flag captured in LOAD, ms ticks counted in PLAY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tempo_q  <= 8'd1;
            ms_cnt_q <= '0;
            end_q    <= 1'b0;
        end else if (state_q == LOAD) begin
            tempo_q  <= (tempo_ms == 8'd0) ? 8'd1 : tempo_ms;
            ms_cnt_q <= '0;
            end_q    <= any_end;
        end else if (state_q == PLAY && ms_tick) begin
            ms_cnt_q <= ms_cnt_q + 8'd1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        qb_tone_gen u_gen (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (state_q == LOAD),
            .code    (rd_code[c]),
            .tick    (tone_tick && state_q == PLAY),
            .silence (silence),
            .sq      (sq[c])
        );
    end

    // Number of voices currently high.
    always_comb begin
        k = '0;
        for (int c = 0; c < N_CH; c++) k = k + ACC_W'(sq[c]);
    end

    assign acc_sum = acc_q + k;

    // First-order delta-sigma: emit 1 whenever the accumulator reaches N_CH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sound <= 1'b0;
        end else if (silence) begin
            acc_q <= '0;
            sound <= 1'b0;
        end else if (acc_sum >= ACC_W'(N_CH)) begin
            acc_q <= acc_sum - ACC_W'(N_CH);
            sound <= 1'b1;
        end else begin
            acc_q <= acc_sum;
            sound <= 1'b0;
        end
    end

    assign sound_n = ~sound;

    // Status outputs follow the FSM one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            playing <= 1'b0;
            led     <= '0;
        end else begin
            playing <= (state_q != IDLE);
            led     <= {state_q != IDLE, 7'(step_q)};
        end
    end

endmodule
